adder_tree_accumulator_signed: RTL



---
 rtl/adder_tree_accumulator_signed.sv | 90 +++++++++
 1 files changed

// File: rtl/adder_tree_accumulator_signed.sv
// Accumulates N_BEATS consecutive signed tree sums into one signed total.
// The total is presented on a valid/ready output port.
module adder_tree_accumulator_signed #(
  parameter int IN_WIDTH  = 8,
  parameter int N_BEATS   = 4,
  localparam int OUT_WIDTH = IN_WIDTH + $clog2(N_BEATS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out
);

  localparam int CNT_W = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                      state, state_d;
  logic signed [OUT_WIDTH-1:0] acc, acc_d;
  logic        [CNT_W-1:0]     beat_cnt, cnt_d;
  logic signed [OUT_WIDTH-1:0] out_d;
  logic signed [OUT_WIDTH-1:0] in_sext;
  logic signed [OUT_WIDTH-1:0] sum;

  // Valid/ready: a transfer happens on a rising edge where both valid and
  // ready are high. in_ready and out_valid come only from the state register,
  // so neither depends combinationally on in_valid or out_ready.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  assign in_sext = OUT_WIDTH'(in);
  assign sum     = acc + in_sext;

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = beat_cnt;
    out_d   = out;
    if (clear) begin
      // Abort wins over any handshake in the same cycle.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              out_d   = sum;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = HOLD;
            end else begin
              acc_d = sum;
              cnt_d = beat_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACCUM;
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACCUM;
      acc      <= '0;
      beat_cnt <= '0;
      out      <= '0;
    end else begin
      state    <= state_d;
      acc      <= acc_d;
      beat_cnt <= cnt_d;
      out      <= out_d;
    end
  end

endmodule
